// File: rtl/writeback_pkg.sv
// Shared types and constants for the uRISC writeback stage.
// Imported by the interface, scoreboard and top.
package wb_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int PEND_W   = 2;
    localparam int RETIRE_W = 16;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PEND_W-1:0] pend_t;

    localparam pend_t PEND_MAX = pend_t'(3);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } wb_state_e;

endpackage

// File: rtl/writeback_if.sv
// Bus between mem/decode and the writeback stage.
// master = mem/decode side, slave = writeback.
interface writeback_if;
    import wb_pkg::*;

    data_t              dest_reg_value_memwb_p1;
    reg_idx_t           dest_reg_index_memwb_p1;
    logic               dest_reg_write_valid_memwb_p1;
    logic               issue_valid_idwb_p1;
    logic               issue_write_idwb_p1;
    reg_idx_t           issue_dest_idwb_p1;
    reg_idx_t           rs_idwb_p1;
    reg_idx_t           rt_idwb_p1;
    logic [1:0]         src_used_idwb_p1;
    logic               halt_idif_p1;
    data_t              rs_value_wbid_p1;
    data_t              rt_value_wbid_p1;
    logic               stall_wbid_p1;
    logic               halted_wb_p1;
    logic [RETIRE_W-1:0] retire_cnt_wb_p1;
    logic               sb_err_wb_p1;

    modport master (
        output dest_reg_value_memwb_p1,
        output dest_reg_index_memwb_p1,
        output dest_reg_write_valid_memwb_p1,
        output issue_valid_idwb_p1,
        output issue_write_idwb_p1,
        output issue_dest_idwb_p1,
        output rs_idwb_p1,
        output rt_idwb_p1,
        output src_used_idwb_p1,
        output halt_idif_p1,
        input  rs_value_wbid_p1,
        input  rt_value_wbid_p1,
        input  stall_wbid_p1,
        input  halted_wb_p1,
        input  retire_cnt_wb_p1,
        input  sb_err_wb_p1
    );

    modport slave (
        input  dest_reg_value_memwb_p1,
        input  dest_reg_index_memwb_p1,
        input  dest_reg_write_valid_memwb_p1,
        input  issue_valid_idwb_p1,
        input  issue_write_idwb_p1,
        input  issue_dest_idwb_p1,
        input  rs_idwb_p1,
        input  rt_idwb_p1,
        input  src_used_idwb_p1,
        input  halt_idif_p1,
        output rs_value_wbid_p1,
        output rt_value_wbid_p1,
        output stall_wbid_p1,
        output halted_wb_p1,
        output retire_cnt_wb_p1,
        output sb_err_wb_p1
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters and the decode stall.
// Errors on counter saturation/underflow are sticky until reset.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       issue_acc,
    input  logic       issue_write,
    input  reg_idx_t   issue_dest,
    input  logic       wr_acc,
    input  reg_idx_t   wr_idx,
    input  reg_idx_t   rs,
    input  reg_idx_t   rt,
    input  logic [1:0] src_used,
    output logic       stall,
    output logic       all_clear,
    output logic       sb_err
);

    pend_t pend     [NUM_REGS];
    pend_t pend_nxt [NUM_REGS];

    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] ovf;
    logic [NUM_REGS-1:0] unf;
    logic                haz_rs;
    logic                haz_rt;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r]      = issue_acc && issue_write &&
                          (issue_dest == reg_idx_t'(r));
            dec[r]      = wr_acc && (wr_idx == reg_idx_t'(r));
            pend_nxt[r] = pend[r];
            ovf[r]      = 1'b0;
            unf[r]      = 1'b0;
            if (inc[r] && !dec[r]) begin
                if (pend[r] == PEND_MAX)
                    ovf[r] = 1'b1;
                else
                    pend_nxt[r] = pend[r] + pend_t'(1);
            end else if (dec[r] && !inc[r]) begin
                if (pend[r] == '0)
                    unf[r] = 1'b1;
                else
                    pend_nxt[r] = pend[r] - pend_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                pend[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            pend   <= pend_nxt;
            sb_err <= sb_err | (|ovf) | (|unf);
        end
    end

    // A last outstanding write retiring now is forwarded by the bypass.
    assign haz_rs = (pend[rs] != '0) &&
                    !((pend[rs] == pend_t'(1)) && dec[rs]);
    assign haz_rt = (pend[rt] != '0) &&
                    !((pend[rt] == pend_t'(1)) && dec[rt]);

    assign stall = !run ||
                   (src_used[0] && haz_rs) ||
                   (src_used[1] && haz_rt);

    always_comb begin
        all_clear = 1'b1;
        for (int r = 0; r < NUM_REGS; r++)
            if (pend[r] != '0)
                all_clear = 1'b0;
    end

endmodule

// File: rtl/writeback.sv
// uRISC writeback stage: register file, bypassed reads,
// scoreboard-driven stall and the halt-drain FSM.
module writeback
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    writeback_if.slave wb
);

    wb_state_e           state;
    wb_state_e           state_nxt;
    data_t               regs [NUM_REGS];
    logic [RETIRE_W-1:0] retire_cnt;
    logic                halted;
    logic                wr_acc;
    logic                issue_acc;
    logic                stall;
    logic                all_clear;
    logic                sb_err;

    assign wr_acc    = wb.dest_reg_write_valid_memwb_p1 &&
                       (state != HALTED);
    assign issue_acc = wb.issue_valid_idwb_p1 && !stall &&
                       (state == RUN) && !wb.halt_idif_p1;

    wb_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst),
        .run         (state == RUN),
        .issue_acc   (issue_acc),
        .issue_write (wb.issue_write_idwb_p1),
        .issue_dest  (wb.issue_dest_idwb_p1),
        .wr_acc      (wr_acc),
        .wr_idx      (wb.dest_reg_index_memwb_p1),
        .rs          (wb.rs_idwb_p1),
        .rt          (wb.rt_idwb_p1),
        .src_used    (wb.src_used_idwb_p1),
        .stall       (stall),
        .all_clear   (all_clear),
        .sb_err      (sb_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (wr_acc) begin
            regs[wb.dest_reg_index_memwb_p1] <= wb.dest_reg_value_memwb_p1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            halted     <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state  <= state_nxt;
            halted <= (state_nxt == HALTED);
            if (wr_acc)
                retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:
                if (wb.halt_idif_p1)
                    state_nxt = DRAIN;
            DRAIN:
                if (all_clear && !wb.dest_reg_write_valid_memwb_p1)
                    state_nxt = HALTED;
            HALTED:
                state_nxt = HALTED;
            default:
                state_nxt = RUN;
        endcase
    end

    assign wb.rs_value_wbid_p1 =
        (wb.dest_reg_write_valid_memwb_p1 &&
         (wb.dest_reg_index_memwb_p1 == wb.rs_idwb_p1)) ?
        wb.dest_reg_value_memwb_p1 : regs[wb.rs_idwb_p1];

    assign wb.rt_value_wbid_p1 =
        (wb.dest_reg_write_valid_memwb_p1 &&
         (wb.dest_reg_index_memwb_p1 == wb.rt_idwb_p1)) ?
        wb.dest_reg_value_memwb_p1 : regs[wb.rt_idwb_p1];

    assign wb.stall_wbid_p1    = stall;
    assign wb.halted_wb_p1     = halted;
    assign wb.retire_cnt_wb_p1 = retire_cnt;
    assign wb.sb_err_wb_p1     = sb_err;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_writeback;
    import wb_pkg::*;

    logic clk;
    logic rst;

    writeback_if bus ();

    writeback dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    data_t       m_regs [8];
    int          m_pend [8];
    int          m_st;          // 0 run, 1 drain, 2 halted
    logic        m_halted;
    logic [15:0] m_ret;
    logic        m_err;
    logic        m_acc_i;
    logic        m_acc_w;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic src_blocked(input int s);
        if (m_pend[s] == 0)
            return 1'b0;
        if (m_pend[s] == 1 && bus.dest_reg_write_valid_memwb_p1 &&
            int'(bus.dest_reg_index_memwb_p1) == s)
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_stall();
        if (m_st != 0)
            return 1'b1;
        if (bus.src_used_idwb_p1[0] && src_blocked(int'(bus.rs_idwb_p1)))
            return 1'b1;
        if (bus.src_used_idwb_p1[1] && src_blocked(int'(bus.rt_idwb_p1)))
            return 1'b1;
        return 1'b0;
    endfunction

    function automatic data_t exp_read(input reg_idx_t s);
        if (bus.dest_reg_write_valid_memwb_p1 &&
            bus.dest_reg_index_memwb_p1 == s)
            return bus.dest_reg_value_memwb_p1;
        return m_regs[s];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_st     = 0;
        m_halted = 1'b0;
        m_ret    = '0;
        m_err    = 1'b0;
        m_acc_i  = 1'b0;
        m_acc_w  = 1'b0;
    endtask

    task automatic check_all();
        chk("rs_value", bus.rs_value_wbid_p1, exp_read(bus.rs_idwb_p1));
        chk("rt_value", bus.rt_value_wbid_p1, exp_read(bus.rt_idwb_p1));
        chk("stall", 16'(bus.stall_wbid_p1), 16'(exp_stall()));
        chk("halted", 16'(bus.halted_wb_p1), 16'(m_halted));
        chk("retire_cnt", bus.retire_cnt_wb_p1, m_ret);
        chk("sb_err", 16'(bus.sb_err_wb_p1), 16'(m_err));
    endtask

    task automatic model_update();
        bit clear;
        int d;
        int w;
        clear   = 1;
        for (int r = 0; r < 8; r++)
            if (m_pend[r] != 0) clear = 0;
        m_acc_w = bus.dest_reg_write_valid_memwb_p1 && m_st != 2;
        m_acc_i = bus.issue_valid_idwb_p1 && !exp_stall() &&
                  m_st == 0 && !bus.halt_idif_p1;
        d = int'(bus.issue_dest_idwb_p1);
        w = int'(bus.dest_reg_index_memwb_p1);
        // Net change per register: +1 for an issue, -1 for a retire.
        if (m_acc_i && bus.issue_write_idwb_p1 && !(m_acc_w && w == d)) begin
            if (m_pend[d] == 3) m_err = 1'b1;
            else m_pend[d] = m_pend[d] + 1;
        end
        if (m_acc_w && !(m_acc_i && bus.issue_write_idwb_p1 && w == d)) begin
            if (m_pend[w] == 0) m_err = 1'b1;
            else m_pend[w] = m_pend[w] - 1;
        end
        if (m_acc_w) begin
            m_regs[w] = bus.dest_reg_value_memwb_p1;
            m_ret     = m_ret + 16'd1;
        end
        if (m_st == 0 && bus.halt_idif_p1)
            m_st = 1;
        else if (m_st == 1 && clear && !bus.dest_reg_write_valid_memwb_p1)
            m_st = 2;
        m_halted = (m_st == 2);
    endtask

    task automatic step();
        #1;
        check_all();
        if (rst)
            model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.dest_reg_value_memwb_p1       = '0;
        bus.dest_reg_index_memwb_p1       = '0;
        bus.dest_reg_write_valid_memwb_p1 = 1'b0;
        bus.issue_valid_idwb_p1           = 1'b0;
        bus.issue_write_idwb_p1           = 1'b0;
        bus.issue_dest_idwb_p1            = '0;
        bus.rs_idwb_p1                    = '0;
        bus.rt_idwb_p1                    = '0;
        bus.src_used_idwb_p1              = '0;
        bus.halt_idif_p1                  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic issue(input int dst);
        idle();
        bus.issue_valid_idwb_p1 = 1'b1;
        bus.issue_write_idwb_p1 = 1'b1;
        bus.issue_dest_idwb_p1  = reg_idx_t'(dst);
    endtask

    task automatic wr(input int idx, input data_t v);
        bus.dest_reg_write_valid_memwb_p1 = 1'b1;
        bus.dest_reg_index_memwb_p1       = reg_idx_t'(idx);
        bus.dest_reg_value_memwb_p1       = v;
    endtask

    reg_idx_t q[$];
    bit       from_q;

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset values
        #1;
        chk("reset_retire", bus.retire_cnt_wb_p1, 16'h0000);
        chk("reset_halted", 16'(bus.halted_wb_p1), 16'h0000);
        chk("reset_sb_err", 16'(bus.sb_err_wb_p1), 16'h0000);

        // Bypass then array read
        idle();
        wr(3, 16'hBEEF);
        bus.rs_idwb_p1 = 3'd3;
        #1;
        chk("bypass_rs", bus.rs_value_wbid_p1, 16'hBEEF);
        step();
        idle();
        bus.rs_idwb_p1 = 3'd3;
        #1;
        chk("array_rs", bus.rs_value_wbid_p1, 16'hBEEF);
        chk("retire_one", bus.retire_cnt_wb_p1, 16'h0001);
        chk("underflow_err", 16'(bus.sb_err_wb_p1), 16'h0001);
        step();

        // RAW stall until retire, bypass in retire cycle
        do_reset();
        issue(2);
        step();
        idle();
        bus.issue_valid_idwb_p1 = 1'b1;
        bus.rs_idwb_p1          = 3'd2;
        bus.src_used_idwb_p1    = 2'b01;
        #1;
        chk("raw_stall", 16'(bus.stall_wbid_p1), 16'h0001);
        step();
        step();
        wr(2, 16'h1357);
        #1;
        chk("raw_release", 16'(bus.stall_wbid_p1), 16'h0000);
        chk("raw_bypass", bus.rs_value_wbid_p1, 16'h1357);
        step();
        idle();
        #1;
        chk("raw_no_err", 16'(bus.sb_err_wb_p1), 16'h0000);
        step();

        // Saturation at 3 in flight
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue(5);
            step();
        end
        idle();
        #1;
        chk("pend3_no_err", 16'(bus.sb_err_wb_p1), 16'h0000);
        issue(5);
        step();
        idle();
        #1;
        chk("overflow_err", 16'(bus.sb_err_wb_p1), 16'h0001);
        step();
        step();
        #1;
        chk("err_sticky", 16'(bus.sb_err_wb_p1), 16'h0001);
        do_reset();
        idle();
        wr(1, 16'h0042);
        step();
        idle();
        #1;
        chk("r1_underflow", 16'(bus.sb_err_wb_p1), 16'h0001);
        step();

        // Same-cycle issue and retire keeps pend at 1
        do_reset();
        issue(4);
        step();
        issue(4);
        wr(4, 16'h4444);
        step();
        idle();
        bus.issue_valid_idwb_p1 = 1'b1;
        bus.rt_idwb_p1          = 3'd4;
        bus.src_used_idwb_p1    = 2'b10;
        #1;
        chk("pend_hold_stall", 16'(bus.stall_wbid_p1), 16'h0001);
        step();

        // Halt drain
        do_reset();
        issue(1);
        step();
        issue(2);
        step();
        idle();
        bus.halt_idif_p1 = 1'b1;
        step();
        idle();
        #1;
        chk("drain_stall", 16'(bus.stall_wbid_p1), 16'h0001);
        chk("drain_halted0", 16'(bus.halted_wb_p1), 16'h0000);
        wr(1, 16'h1111);
        step();
        idle();
        wr(2, 16'h2222);
        step();
        idle();
        #1;
        chk("drain_pend0_halted0", 16'(bus.halted_wb_p1), 16'h0000);
        step();
        #1;
        chk("halted1", 16'(bus.halted_wb_p1), 16'h0001);
        chk("halt_retire", bus.retire_cnt_wb_p1, 16'h0002);
        wr(1, 16'h9999);
        step();
        idle();
        bus.rs_idwb_p1 = 3'd1;
        #1;
        chk("halted_reg_kept", bus.rs_value_wbid_p1, 16'h1111);
        chk("halted_retire_kept", bus.retire_cnt_wb_p1, 16'h0002);
        step();

        // Asynchronous reset during drain
        do_reset();
        wr(0, 16'h0F0F);
        step();
        issue(6);
        step();
        idle();
        bus.halt_idif_p1 = 1'b1;
        step();
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_retire", bus.retire_cnt_wb_p1, 16'h0000);
        chk("arst_sb_err", 16'(bus.sb_err_wb_p1), 16'h0000);
        chk("arst_stall", 16'(bus.stall_wbid_p1), 16'h0000);
        chk("arst_halted", 16'(bus.halted_wb_p1), 16'h0000);
        chk("arst_rs", bus.rs_value_wbid_p1, 16'h0000);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            idle();
            from_q = 0;
            if (q.size() > 0 && $urandom_range(1, 0) == 1) begin
                wr(int'(q[0]), data_t'($urandom));
                from_q = 1;
            end else if ($urandom_range(31, 0) == 0) begin
                wr(int'($urandom_range(7, 0)), data_t'($urandom));
            end
            bus.issue_valid_idwb_p1 = ($urandom_range(3, 0) != 0);
            bus.issue_write_idwb_p1 = $urandom_range(1, 0) == 1;
            bus.issue_dest_idwb_p1  = reg_idx_t'($urandom_range(7, 0));
            bus.rs_idwb_p1          = reg_idx_t'($urandom_range(7, 0));
            bus.rt_idwb_p1          = reg_idx_t'($urandom_range(7, 0));
            bus.src_used_idwb_p1    = 2'($urandom_range(3, 0));
            step();
            if (from_q && m_acc_w)
                void'(q.pop_front());
            if (m_acc_i && bus.issue_write_idwb_p1)
                q.push_back(bus.issue_dest_idwb_p1);
        end

        // Random-traffic halt drain
        idle();
        bus.halt_idif_p1 = 1'b1;
        step();
        for (int n = 0; n < 40; n++) begin
            idle();
            if ($urandom_range(1, 0) == 1)
                wr(int'($urandom_range(7, 0)), data_t'($urandom));
            bus.rs_idwb_p1 = reg_idx_t'($urandom_range(7, 0));
            step();
        end

        // Retire counter wrap
        do_reset();
        for (int n = 0; n < 65535; n++) begin
            idle();
            wr(int'($urandom_range(7, 0)), data_t'($urandom));
            step();
        end
        idle();
        #1;
        chk("retire_ffff", bus.retire_cnt_wb_p1, 16'hFFFF);
        wr(7, 16'h7777);
        step();
        idle();
        #1;
        chk("retire_wrap", bus.retire_cnt_wb_p1, 16'h0000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final pipeline stage of the uRISC core; consumes the mem-stage result bus.
- Owns the 8x16 architectural register file.
- Provides two bypassed read ports and a per-register pending-write scoreboard to decode, which drives a decode stall.
- Runs a halt-drain FSM so the core stops only after all in-flight writes retire.

Parameters:
- NUM_REGS, 8, architectural registers; index width is clog2(NUM_REGS).
- DATA_W, 16, register width.
- PEND_W, 2, scoreboard counter width per register; maximum is 3 in flight.
- RETIRE_W, 16, retire counter width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- dest_reg_value_memwb_p1  in  16  writeback data
- dest_reg_index_memwb_p1  in  3  writeback register index
- dest_reg_write_valid_memwb_p1  in  1  writeback strobe
- issue_valid_idwb_p1  in  1  decode presents an instruction this cycle
- issue_write_idwb_p1  in  1  that instruction writes a register
- issue_dest_idwb_p1  in  3  its destination index
- rs_idwb_p1  in  3  source A index
- rt_idwb_p1  in  3  source B index
- src_used_idwb_p1  in  2  bit0 = rs used, bit1 = rt used
- halt_idif_p1  in  1  decode saw HALT
- rs_value_wbid_p1  out  16  source A value
- rt_value_wbid_p1  out  16  source B value
- stall_wbid_p1  out  1  decode must hold its instruction
- halted_wb_p1  out  1  core drained and halted
- retire_cnt_wb_p1  out  16  accepted writebacks
- sb_err_wb_p1  out  1  sticky scoreboard over/underflow

Behaviour:
- Reset (rst low, asynchronous), all outputs and state:
  - registers = 0, all pend counters = 0
  - FSM = RUN, halted = 0, retire_cnt = 0, sb_err = 0
- Register write:
  - Occurs at the posedge when write_valid is high and FSM is not HALTED.
  - Stored value is visible from the array on the next cycle.
- Read ports are combinational. Each returns the array value, except when write_valid && index == source index, where it returns dest_reg_value_memwb_p1 (same-cycle bypass). rs == rt is legal; both ports bypass.
- Scoreboard: pend[r] counts issued-but-unretired writes to r.
  - Issue accepted = issue_valid && !stall && FSM == RUN && !halt_idif.
  - Accepted issue with issue_write increments pend[dest].
  - Each accepted write decrements pend[index].
  - Increment and decrement on the same register in the same cycle: pend is unchanged.
  - Increment at 3: saturate at 3 and set sb_err.
  - Decrement at 0: hold 0 and set sb_err. sb_err clears only on reset.
- Stall (combinational) is high if either condition holds:
  - FSM != RUN
  - a used source s has pend[s] != 0, unless pend[s] == 1 and the current write retires s (that value is bypassed).
  - Destination hazards (WAW) never stall; counting handles them.
- FSM:
  - RUN -> DRAIN when halt_idif_p1 is high; the halt-cycle issue is not accepted.
  - DRAIN -> HALTED when all pend == 0 and write_valid is low in that cycle.
  - HALTED is terminal until reset. Writes in HALTED are ignored and not counted.
  - halted_wb_p1 is registered and high exactly while in HALTED.
- retire_cnt increments on every accepted write and wraps 0xFFFF -> 0x0000.
- Reset asserted mid-drain returns to RUN with all state cleared.

Decomposition:
- Shared package wb_pkg contains:
  - reg_idx_t (3 bits), data_t (16 bits)
  - wb_state_e {RUN, DRAIN, HALTED}
  - constants NUM_REGS and PEND_MAX = 3
- One sub-module, wb_scoreboard: holds the pend counters, saturation/error logic, the stall computation, and the all_clear output. writeback instantiates it alongside the register array and FSM.

Test Plan:
- Write R3 = 0xBEEF with rs = 3 in the same cycle -> rs_value = 0xBEEF that cycle (bypass); next cycle with no write -> rs_value = 0xBEEF from the array; retire_cnt = 1.
- Issue a write to R2, then next cycle rs = 2 with src_used = 01 -> stall = 1 until the write to R2 arrives. In the retire cycle, stall = 0 and rs_value equals the bypassed data.
- Issue a write to R5 three times with no retire -> pend[5] = 3, sb_err = 0; a fourth issue -> sb_err = 1 and stays 1. A write to R1 with pend[1] = 0 after reset -> sb_err = 1.
- Same-cycle issue to R4 and retire of R4 with pend[4] = 1 -> pend stays 1 and stall for rt = 4 remains 1 next cycle.
- Two writes in flight, pulse halt_idif -> stall = 1 immediately; halted = 0 until the second write retires; halted = 1 the cycle after pend reaches zero. A later write -> register unchanged, retire_cnt unchanged.
- 65536 writes -> retire_cnt wraps to 0x0000. Assert rst during DRAIN -> all outputs return to reset values asynchronously.
